// File: rtl/ahb_slv_dec.sv
// AHB-Lite address decoder and response mux for slaves s0..s2, with s3 as the default error slave.
// Selects are combinational from the address phase; the response follows the registered data-phase slave and stalls while that slave holds hready low.
module ahb_slv_dec #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFF0_0000,
    parameter logic [31:0] S1_BASE = 32'h2000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFF0_0000,
    parameter logic [31:0] S2_BASE = 32'h4000_0000,
    parameter logic [31:0] S2_MASK = 32'hF000_0000,
    parameter int          CNT_W   = 16
) (
    input  logic             pll_core_cpuclk,
    input  logic             pad_cpu_rst,
    input  logic [31:0]      haddr,
    input  logic [1:0]       htrans,
    output logic             hready,
    output logic [31:0]      hrdata,
    output logic [1:0]       hresp,
    output logic             hsel_s0,
    output logic             hsel_s1,
    output logic             hsel_s2,
    output logic             hsel_s3,
    input  logic [31:0]      hrdata_s0,
    input  logic [31:0]      hrdata_s1,
    input  logic [31:0]      hrdata_s2,
    input  logic [31:0]      hrdata_s3,
    input  logic             hready_s0,
    input  logic             hready_s1,
    input  logic             hready_s2,
    input  logic             hready_s3,
    input  logic [1:0]       hresp_s0,
    input  logic [1:0]       hresp_s1,
    input  logic [1:0]       hresp_s2,
    input  logic [1:0]       hresp_s3,
    output logic [CNT_W-1:0] err_cnt,
    output logic [31:0]      err_addr
);

    logic             m0, m1, m2;
    logic [3:0]       hsel;
    logic [3:0]       dsel_q, dsel_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]      err_addr_q, err_addr_d;

    // Priority s0 > s1 > s2 resolves overlapping regions; anything else falls to s3.
    always_comb begin
        m0   = ((haddr & S0_MASK) == S0_BASE);
        m1   = ((haddr & S1_MASK) == S1_BASE);
        m2   = ((haddr & S2_MASK) == S2_BASE);
        hsel = 4'b0000;
        if (htrans[1] && hready) begin
            if (m0) begin
                hsel = 4'b0001;
            end else if (m1) begin
                hsel = 4'b0010;
            end else if (m2) begin
                hsel = 4'b0100;
            end else begin
                hsel = 4'b1000;
            end
        end
    end

    assign hsel_s0 = hsel[0];
    assign hsel_s1 = hsel[1];
    assign hsel_s2 = hsel[2];
    assign hsel_s3 = hsel[3];

    always_comb begin
        hready = 1'b1;
        hresp  = 2'b00;
        hrdata = 32'h0000_0000;
        case (dsel_q)
            4'b0001: begin hready = hready_s0; hresp = hresp_s0; hrdata = hrdata_s0; end
            4'b0010: begin hready = hready_s1; hresp = hresp_s1; hrdata = hrdata_s1; end
            4'b0100: begin hready = hready_s2; hresp = hresp_s2; hrdata = hrdata_s2; end
            4'b1000: begin hready = hready_s3; hresp = hresp_s3; hrdata = hrdata_s3; end
            default: ;
        endcase
    end

    always_comb begin
        dsel_d     = hready ? hsel : dsel_q;
        err_addr_d = hsel[3] ? haddr : err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (hready && (hresp == 2'b01) && (dsel_q != 4'b0000) &&
            (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pll_core_cpuclk) begin
        if (pad_cpu_rst) begin
            dsel_q     <= 4'b0000;
            err_cnt_q  <= '0;
            err_addr_q <= 32'h0000_0000;
        end else begin
            dsel_q     <= dsel_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;

endmodule
